div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 4: number of cycles allowed for the combinational divider path to settle; legal range 1..15.
REQ-002 SHALL have ports clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have ports rst_n, input, 1, reset; reset is asynchronous and active-low.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1: the request handshake.
REQ-005 SHALL have port in_op, input, 2: 00 div, 01 divu, 10 rem, 11 remu.
REQ-006 SHALL have port in_word, input, 1: 1 selects the 32-bit W variant.
REQ-007 SHALL have ports in_a input 64 and in_b input 64: dividend and divisor.
REQ-008 SHALL have ports div_in1 output 64, div_in2 output 64 and div_control output 2: registered operands driven to the downstream combinational divider.
REQ-009 SHALL have port div_out, input, 64: the divider result.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1 and out_result output 64: the result handshake.
REQ-011 SHALL have port flush, input, 1: synchronous abort.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-013 Accept SHALL occur when in_valid and in_ready are both 1 at an edge; only one operation SHALL be in flight at a time.
REQ-014 On accept, operands SHALL be registered: for in_word=0, in_a and in_b are passed unchanged; for in_word=1, the low 32 bits are sign-extended when in_op[0]=0 and zero-extended when in_op[0]=1.
REQ-015 On accept, div_control SHALL be registered as in_op; div_in1, div_in2 and div_control SHALL hold stable until the next accept.
REQ-016 Divide-by-zero SHALL be detected on the registered divisor (all 64 bits zero after extension).
  - quotient ops: result all ones.
  - remainder ops: result is the extended dividend.
REQ-017 Signed overflow SHALL be detected for in_op[0]=0 with dividend = most-negative (64-bit, or 32-bit when in_word=1) and divisor = -1.
  - div: result = dividend.
  - rem: result = 0.
REQ-018 For a special case (REQ-016 or REQ-017), the FSM SHALL go IDLE->DONE at the accept edge, with out_valid=1 in the very next cycle.
REQ-019 Otherwise the FSM SHALL go IDLE->BUSY, load the counter with DIV_CYCLES-1, and decrement it each cycle.
REQ-020 In BUSY with counter 0, the next edge SHALL capture div_out into out_result and go to DONE; the FSM is therefore BUSY for exactly DIV_CYCLES cycles.
REQ-021 For in_word=1, every result, special-case results included, SHALL be bits [31:0] sign-extended to 64 bits; this applies to divuw and remuw as well.
REQ-022 In DONE, out_result SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 In DONE with out_ready=1, the FSM SHALL return to IDLE; the next accept can occur no earlier than the following edge, so there is no same-cycle turnaround.
REQ-024 flush=1 at an edge SHALL force IDLE and clear out_valid and the counter from any state; any result is dropped.
REQ-025 flush SHALL have priority over accept and over out_ready.

Reset
REQ-026 While rst_n=0, the block SHALL be asynchronously in IDLE with:
  - out_valid=0, in_ready=1;
  - out_result, div_in1, div_in2 and counter = 0;
  - div_control=00.
REQ-027 Assertion of rst_n during BUSY or DONE SHALL abort the operation; no out_valid pulse SHALL follow reset release.

Verification
REQ-028 Basic div, DIV_CYCLES=4: in_op=00, a=-7, b=2 -> out_valid exactly 4 cycles after the accept cycle ends, out_result=-3; with rem, out_result=-1.
REQ-029 Divide-by-zero: a=0x1234, b=0, divu -> out_valid in the next cycle, out_result=0xFFFF_FFFF_FFFF_FFFF; with remu -> 0x1234.
REQ-030 Overflow: a=0x8000_0000_0000_0000, b=-1, div -> out_result=a; with in_word=1 and a=0x8000_0000, divw -> out_result=0xFFFF_FFFF_8000_0000.
REQ-031 Word unsigned: in_word=1, divuw, a=0xFFFF_FFFF, b=1 -> out_result=0xFFFF_FFFF_FFFF_FFFF.
REQ-032 Backpressure and flush:
  - out_ready held 0 for 5 cycles -> out_result stable and in_ready=0 throughout.
  - flush asserted in BUSY -> IDLE next cycle, and no out_valid pulse.
REQ-033 Async reset: rst_n pulsed low mid-BUSY, between clock edges -> outputs cleared immediately, and in_ready=1.

Source files
------------

// File: rtl/div_seq_if.sv
// Request, result and divider-side signals of the sequential divider wrapper.
// The slave side is the wrapper; the master side is its environment.
interface div_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_word;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [63:0] div_in1;
    logic [63:0] div_in2;
    logic [1:0]  div_control;
    logic [63:0] div_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;

    modport slave (
        input  in_valid, in_op, in_word, in_a, in_b,
        input  div_out, out_ready,
        output in_ready, div_in1, div_in2, div_control,
        output out_valid, out_result
    );

    modport master (
        output in_valid, in_op, in_word, in_a, in_b,
        output div_out, out_ready,
        input  in_ready, div_in1, div_in2, div_control,
        input  out_valid, out_result
    );
endinterface

// File: rtl/div_seq.sv
// Sequencer around a multicycle combinational divider: registers operands,
// short-circuits divide-by-zero / overflow, and waits DIV_CYCLES for settle.
module div_seq #(
    parameter int DIV_CYCLES = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    div_seq_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] in1_q, in1_d;
    logic [63:0] in2_q, in2_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        word_q, word_d;
    logic [63:0] res_q, res_d;

    logic [63:0] ext_a, ext_b;
    logic [63:0] min_neg;
    logic        b_zero, ovf;
    logic [63:0] spec_res;

    // W results are always the low word sign-extended, even for unsigned ops
    function automatic logic [63:0] fix_word(input logic w, input logic [63:0] v);
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    // Operand extension and special-case detection on the values being registered
    always_comb begin
        ext_a = bus.in_a;
        ext_b = bus.in_b;
        if (bus.in_word) begin
            if (bus.in_op[0]) begin
                ext_a = {32'd0, bus.in_a[31:0]};
                ext_b = {32'd0, bus.in_b[31:0]};
            end else begin
                ext_a = {{32{bus.in_a[31]}}, bus.in_a[31:0]};
                ext_b = {{32{bus.in_b[31]}}, bus.in_b[31:0]};
            end
        end
        min_neg = bus.in_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        b_zero  = (ext_b == 64'd0);
        ovf     = !bus.in_op[0] && (ext_a == min_neg) && (ext_b == '1);
        if (b_zero)
            spec_res = bus.in_op[1] ? ext_a : '1;
        else
            spec_res = bus.in_op[1] ? 64'd0 : ext_a;
    end

    // FSM next state; flush beats accept and out_ready
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        ctrl_d  = ctrl_q;
        word_d  = word_q;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        in1_d  = ext_a;
                        in2_d  = ext_b;
                        ctrl_d = bus.in_op;
                        word_d = bus.in_word;
                        if (b_zero || ovf) begin
                            res_d   = fix_word(bus.in_word, spec_res);
                            state_d = DONE;
                        end else begin
                            cnt_d   = 4'(DIV_CYCLES - 1);
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        res_d   = fix_word(word_q, bus.div_out);
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            in1_q   <= 64'd0;
            in2_q   <= 64'd0;
            ctrl_q  <= 2'b00;
            word_q  <= 1'b0;
            res_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            ctrl_q  <= ctrl_d;
            word_q  <= word_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.out_result  = res_q;
    assign bus.div_in1     = in1_q;
    assign bus.div_in2     = in2_q;
    assign bus.div_control = ctrl_q;
endmodule
